lenet_layer_ctrl: RTL and testbench
===================================

LENET_LAYER_CTRL -- requirements
Module: lenet_layer_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 5, meaning layers sequenced in order conv_1, pool_1, conv_2, pool_2, fc.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between one layer's enable falling and the next rising.
REQ-003 The block SHALL have parameter MASK_CYCLES, default 2, meaning cycles after an enable rises during which that layer's finish is ignored.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum RUN cycles allowed per layer.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle request to run the whole network.
REQ-008 The block SHALL have port layer_finish, input, NUM_LAYERS bits: per-layer finish flags (level or pulse).
REQ-009 The block SHALL have port layer_en, output, NUM_LAYERS bits: per-layer enables, held high for the whole run (e.g. pool_2_en).
REQ-010 The block SHALL have port cur_layer, output, 3 bits: index of the active or most recent layer.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and GAP.
REQ-012 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-013 The block SHALL have port error, output, 1 bit: high in ERR.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, GAP, DONE and ERR; all outputs SHALL be registered.
REQ-015 start SHALL be accepted only in IDLE, DONE or ERR: next state RUN, cur_layer=0, timers cleared. start in RUN or GAP SHALL be ignored.
REQ-016 In RUN, layer_en SHALL be one-hot at bit cur_layer and all other bits SHALL be 0.
REQ-017 In RUN, layer_finish[cur_layer] SHALL be sampled only after MASK_CYCLES cycles in RUN, so a stale finish from the previous run is filtered.
REQ-018 When a sampled finish is seen, layer_en SHALL fall on the next edge and the state SHALL become GAP. Downstream layers rely on this gap for rising-edge detection.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles with layer_en all-zero.
REQ-020 After GAP, cur_layer SHALL increment and the state SHALL return to RUN. If cur_layer was NUM_LAYERS-1, the state SHALL go to DONE and cur_layer SHALL hold.
REQ-021 layer_finish bits other than cur_layer SHALL be ignored in every state.
REQ-022 Latency: layer_en[0] SHALL rise 1 cycle after start is sampled.
REQ-023 Latency: each next enable SHALL rise GAP_CYCLES+1 cycles after the sampled finish.
REQ-024 DONE and ERR SHALL hold (outputs static) until start or rst.

Reset
REQ-025 On rst the block SHALL enter IDLE with layer_en=0, cur_layer=0, busy=0, done=0, error=0, and all counters at 0.
REQ-026 rst asserted mid-RUN SHALL drop layer_en on the next edge.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 With LAYER_TIMEOUT_EN defined, a per-layer RUN counter SHALL count. Reaching TIMEOUT_CYCLES without a finish SHALL force layer_en=0 and enter ERR with error=1. cur_layer SHALL keep the stuck layer index.
REQ-029 With LAYER_TIMEOUT_EN undefined, the counter and ERR state SHALL be absent and error SHALL be tied to 0.

Structure
REQ-030 A shared package lenet_pkg SHALL hold the FSM state enum, the layer index constants (L_CONV1=0 ... L_FC=4) and NUM_LAYERS.
REQ-031 Sub-module: none is required. An optional lenet_cycle_timer (load/expire counter) MAY be used for the GAP, MASK and timeout counts.

Verification
REQ-032 Normal run: start, with each finish pulsed 10 cycles after its enable -> enables 00001, 00010, 00100, 01000, 10000 in order, each gap 2 cycles, then done=1 and busy=0.
REQ-033 Stale finish: layer_finish[3] held high before pool_2 starts -> layer_en[3] stays high for at least 3 cycles. It falls only after the mask expires, on the next edge.
REQ-034 Wrong-layer finish: during layer 1, pulse layer_finish[2] -> no state change, and layer_en stays 00010.
REQ-035 Mid-run reset: rst during layer 2 -> next cycle layer_en=0, IDLE, and all outputs at 0. A following start restarts at layer 0.
REQ-036 Timeout (LAYER_TIMEOUT_EN, TIMEOUT_CYCLES=100): never finish layer 3 -> after 100 RUN cycles layer_en=0, error=1, cur_layer=3. start then reruns from layer 0 with error=0.
REQ-037 Start while busy: pulse start during layer 2 -> ignored, and the sequence completes normally.

Source files
------------

// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_pkg
// Description : Shared sequencer state encoding, layer indices and layer count
// Revision    : 1.0
// ============================================================================
package lenet_pkg;

  localparam int NUM_LAYERS = 5;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC    = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lenet_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lenet_layer_ctrl
// Description : Sequences the LeNet layers one at a time with masked finish
//               sampling and idle gaps; LAYER_TIMEOUT_EN adds a stuck-layer
//               timeout that ends in an error state.
// Revision    : 1.0
// ============================================================================
module lenet_layer_ctrl #(
  parameter int NUM_LAYERS     = lenet_pkg::NUM_LAYERS,
  parameter int GAP_CYCLES     = 2,
  parameter int MASK_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_finish,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  import lenet_pkg::*;

  localparam int CNT_MAX = max3(MASK_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_MASK       = CNT_W'(MASK_CYCLES);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       C_LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [2:0]       C_FIRST      = 3'(L_CONV1);
`ifdef LAYER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RUN_SAT    = C_TO_LAST;
`else
  localparam logic [CNT_W-1:0] C_RUN_SAT    = C_MASK;
`endif

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_cur;
  logic [2:0]              w_cur_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [NUM_LAYERS-1:0]   r_en;
  logic [NUM_LAYERS-1:0]   w_en_nxt;
  logic                    r_busy;
  logic                    r_done;

  // One counter serves both phases: cycles spent in RUN (mask and timeout)
  // and cycles spent in GAP; it restarts at 0 on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_cur_nxt   = C_FIRST;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if ((r_cnt >= C_MASK) && layer_finish[r_cur]) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end
`ifdef LAYER_TIMEOUT_EN
        else if (r_cnt == C_TO_LAST) begin
          w_state_nxt = ST_ERR;
          w_cnt_nxt   = '0;
        end
`endif
        else if (r_cnt != C_RUN_SAT) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt >= C_GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_cur == C_LAST_LAYER) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_cur_nxt   = r_cur + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cur_nxt   = C_FIRST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they stay registered yet
  // change on the same edge as the state.
  always_comb begin
    w_en_nxt = '0;
    if (w_state_nxt == ST_RUN) begin
      w_en_nxt = NUM_LAYERS'(1) << w_cur_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= C_FIRST;
      r_cnt   <= '0;
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_GAP);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef LAYER_TIMEOUT_EN
  logic r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (w_state_nxt == ST_ERR);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign layer_en  = r_en;
  assign cur_layer = r_cur;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lenet_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lenet_layer_ctrl
// Description : Scoreboard bench for lenet_layer_ctrl with a timeline model
// Revision    : 1.0
// ============================================================================
module tb_lenet_layer_ctrl;
  localparam int NL   = 5;
  localparam int GAP  = 2;
  localparam int MASK = 2;
`ifdef LAYER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  localparam int EV_EN   = 0;
  localparam int EV_OFF  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int kind;
    int layer;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NL-1:0] layer_finish;
  logic [NL-1:0] layer_en;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          done;
  logic          error;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;
  logic [NL-1:0] prev_en;
  logic          prev_done;
  logic          prev_err;
  ev_t           q[$];

  lenet_layer_ctrl #(
    .NUM_LAYERS    (NL),
    .GAP_CYCLES    (GAP),
    .MASK_CYCLES   (MASK),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .layer_finish(layer_finish),
    .layer_en    (layer_en),
    .cur_layer   (cur_layer),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input int layer, input int c);
    ev_t e;
    e.kind = kind;
    e.layer = layer;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int layer);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL event: got kind %0d layer %0d at cycle %0d, expected none", kind, layer, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind == kind && e.layer == layer && e.cyc == cyc) n_pass++;
      else $display("FAIL event: got kind %0d layer %0d cycle %0d, expected kind %0d layer %0d cycle %0d",
                    kind, layer, cyc, e.kind, e.layer, e.cyc);
    end
  endtask

  function automatic int idx_of(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: turns output edges into events and checks them against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (layer_en !== prev_en) begin
        if (prev_en == '0) begin
          got_ev(EV_EN, idx_of(layer_en));
          chk("en_onehot", $countones(layer_en), 1);
          chk("en_cur_layer", cur_layer, idx_of(layer_en));
          chk("en_busy", busy, 1);
        end else if (layer_en == '0) begin
          got_ev(EV_OFF, idx_of(prev_en));
        end else begin
          got_ev(EV_EN, idx_of(layer_en));
        end
      end
      if (done && !prev_done) got_ev(EV_DONE, int'(cur_layer));
      if (error && !prev_err) got_ev(EV_ERR, int'(cur_layer));
    end
    prev_en   = layer_en;
    prev_done = done;
    prev_err  = error;
  end

  // Modes: 0 fixed 10-cycle finishes, 1 stale pool_2 finish, 2 wrong-layer
  // finish during layer 1, 3 reset during layer 2, 4 start while busy,
  // 5 layer 3 never finishes, 6 random finish delays.
  task automatic run_case(input int mode);
    int R[NL];
    int A[NL];
    int d[NL];
    int s0, last, rst_edge, guard;
    logic [NL-1:0] fin, forbid;

    s0 = cyc + 1;
    for (int k = 0; k < NL; k++) d[k] = (mode == 0) ? 10 : int'($urandom_range(MASK + 1, 12));
    if (mode == 1) d[3] = MASK + 1;
    if (mode == 5) d[3] = TO;
    R[0] = s0;
    for (int k = 0; k < NL; k++) begin
      A[k] = R[k] + d[k];
      if (k < NL - 1) R[k+1] = A[k] + GAP;
    end
    rst_edge = R[2] + 2;

    if (mode == 3) begin
      for (int k = 0; k < 2; k++) begin
        expect_ev(EV_EN, k, R[k]);
        expect_ev(EV_OFF, k, A[k]);
      end
      expect_ev(EV_EN, 2, R[2]);
      expect_ev(EV_OFF, 2, rst_edge);
      last = rst_edge;
    end else if (mode == 5) begin
      for (int k = 0; k < 4; k++) begin
        expect_ev(EV_EN, k, R[k]);
        expect_ev(EV_OFF, k, A[k]);
      end
      expect_ev(EV_ERR, 3, A[3]);
      last = A[3];
    end else begin
      for (int k = 0; k < NL; k++) begin
        expect_ev(EV_EN, k, R[k]);
        expect_ev(EV_OFF, k, A[k]);
      end
      expect_ev(EV_DONE, NL - 1, A[NL-1] + GAP);
      last = A[NL-1] + GAP;
    end

    for (int e = s0; e <= last; e++) begin
      start = (e == s0) || (mode == 4 && e == R[2] + 1);
      rst   = (mode == 3 && e == rst_edge);
      forbid = '0;
      fin    = '0;
      for (int k = 0; k < NL; k++) begin
        if (e > R[k] && e <= A[k]) forbid[k] = 1'b1;
        if (e == A[k] && !(mode == 5 && k == 3)) fin[k] = 1'b1;
      end
      if (mode != 0) fin = fin | (NL'($urandom) & ~forbid);
      if (mode == 1 && e > R[2] && e <= A[3]) fin[3] = 1'b1;
      if (mode == 2 && e > R[1] && e < A[1]) fin[2] = 1'b1;
      layer_finish = fin;
      step();
      if (e == s0) begin
        chk("start_busy", busy, 1);
        chk("start_error", error, 0);
        chk("start_cur", cur_layer, 0);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    layer_finish = '0;

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("drain_outstanding", q.size(), 0);
    q.delete();

    repeat (3) step();
    if (mode == 3) begin
      chk("rst_en", layer_en, 0);
      chk("rst_cur", cur_layer, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
    end else if (mode == 5) begin
      chk("to_en", layer_en, 0);
      chk("to_error", error, 1);
      chk("to_cur", cur_layer, 3);
      chk("to_busy", busy, 0);
    end else begin
      chk("done_hold", done, 1);
      chk("done_busy", busy, 0);
      chk("done_en", layer_en, 0);
      chk("done_cur", cur_layer, NL - 1);
      chk("done_error", error, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    layer_finish = '1;
    repeat (3) step();
    chk("reset_en", layer_en, 0);
    chk("reset_cur", cur_layer, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    start = 1'b0;
    layer_finish = '0;
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    run_case(0);
    run_case(2);
    run_case(1);
    run_case(4);
    run_case(3);
    run_case(0);
`ifdef LAYER_TIMEOUT_EN
    run_case(5);
    run_case(6);
`endif
    for (int i = 0; i < 4; i++) begin
      run_case(($urandom_range(0, 1) == 0) ? 6 : int'($urandom_range(1, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
